// File: rtl/char_buff.sv
// char_buff: buffers a PROC character stream, hashes each sliding L-byte window
// through an external MD5 core and reports/serves the first matching window.
module char_buff #(
    parameter int unsigned BUFF_DEPTH    = 1024,
    parameter int unsigned MAX_STR_BYTES = 55
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         proc_start,
    input  logic [15:0]  proc_num_bytes,
    input  logic [7:0]   proc_data,
    input  logic         proc_data_valid,
    input  logic [127:0] proc_target_hash,
    input  logic [15:0]  proc_str_len,
    input  logic         proc_match_char_next,
    output logic         proc_done,
    output logic         proc_match,
    output logic [15:0]  proc_byte_pos,
    output logic [7:0]   proc_match_char,
    output logic [7:0]   md5_data,
    output logic         md5_data_valid,
    output logic         md5_last,
    input  logic         md5_ready,
    input  logic         md5_hash_valid,
    input  logic [127:0] md5_hash
);
    localparam int unsigned AW = $clog2(BUFF_DEPTH);
    localparam int unsigned PW = 17;
    localparam int unsigned LW = 13;

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_FEED, S_WAIT_HASH, S_DRAIN, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [7:0]    mem [BUFF_DEPTH];
    logic [15:0]   num_bytes;
    logic [LW-1:0] str_bytes;
    logic [LW-1:0] feed_idx;
    logic [PW-1:0] wr_ptr, rx_count, pos;
    logic [PW-1:0] win_end_c, n_eff_c;
    logic [AW-1:0] rd_ptr;

    logic wr_en_c, fill_skip_c, fill_go_c, feed_accept_c, feed_done_c, feed_load_c;
    logic hash_hit_c, hash_miss_c, drain_done_c;
    logic unused_len_bits;

    assign unused_len_bits = ^proc_str_len[2:0];
    assign win_end_c = pos + PW'(str_bytes);
    assign n_eff_c   = (PW'(num_bytes) > PW'(BUFF_DEPTH)) ? PW'(BUFF_DEPTH) : PW'(num_bytes);
    assign wr_en_c   = !proc_start && proc_data_valid && (rx_count < PW'(num_bytes));

    // Write side: counts every byte of the run, stores only the first BUFF_DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rx_count <= '0;
        end else if (proc_start) begin
            wr_ptr   <= '0;
            rx_count <= '0;
        end else if (wr_en_c) begin
            rx_count <= rx_count + PW'(1);
            if (wr_ptr < PW'(BUFF_DEPTH)) wr_ptr <= wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c && (wr_ptr < PW'(BUFF_DEPTH))) mem[AW'(wr_ptr)] <= proc_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next state; a new proc_start always restarts the run
    always_comb begin
        state_nx = state;
        if (proc_start) begin
            state_nx = S_FILL;
        end else begin
            case (state)
                S_IDLE:      state_nx = S_IDLE;
                S_FILL: begin
                    if (fill_skip_c)    state_nx = S_DRAIN;
                    else if (fill_go_c) state_nx = S_FEED;
                end
                S_FEED:      if (feed_done_c) state_nx = S_WAIT_HASH;
                S_WAIT_HASH: begin
                    if (hash_hit_c)       state_nx = S_DRAIN;
                    else if (hash_miss_c) state_nx = S_FILL;
                end
                S_DRAIN:     if (drain_done_c) state_nx = S_DONE;
                S_DONE:      state_nx = S_IDLE;
                default:     state_nx = S_IDLE;
            endcase
        end
    end

    // Control strobes decoded from state and handshakes
    always_comb begin
        fill_skip_c   = (str_bytes == '0) || (PW'(str_bytes) > PW'(MAX_STR_BYTES))
                        || (win_end_c > n_eff_c);
        fill_go_c     = wr_ptr >= win_end_c;
        feed_accept_c = md5_data_valid && md5_ready;
        feed_done_c   = (state == S_FEED) && feed_accept_c && md5_last;
        feed_load_c   = (state == S_FEED) && (!md5_data_valid || md5_ready)
                        && !feed_done_c && (feed_idx < str_bytes);
        hash_hit_c    = (state == S_WAIT_HASH) && md5_hash_valid
                        && (md5_hash == proc_target_hash);
        hash_miss_c   = (state == S_WAIT_HASH) && md5_hash_valid
                        && (md5_hash != proc_target_hash);
        drain_done_c  = rx_count == PW'(num_bytes);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_bytes       <= '0;
            str_bytes       <= '0;
            pos             <= '0;
            feed_idx        <= '0;
            rd_ptr          <= '0;
            proc_done       <= 1'b0;
            proc_match      <= 1'b0;
            proc_byte_pos   <= '0;
            proc_match_char <= '0;
            md5_data        <= '0;
            md5_data_valid  <= 1'b0;
            md5_last        <= 1'b0;
        end else begin
            proc_done       <= 1'b0;
            proc_match_char <= mem[rd_ptr];
            if (proc_match_char_next) rd_ptr <= rd_ptr + AW'(1);
            if (proc_start) begin
                num_bytes      <= proc_num_bytes;
                str_bytes      <= proc_str_len[15:3];
                pos            <= '0;
                feed_idx       <= '0;
                proc_match     <= 1'b0;
                proc_byte_pos  <= '0;
                md5_data_valid <= 1'b0;
                md5_last       <= 1'b0;
            end else begin
                case (state)
                    S_FILL: feed_idx <= '0;
                    S_FEED: begin
                        if (feed_done_c) begin
                            md5_data_valid <= 1'b0;
                            md5_last       <= 1'b0;
                        end else if (feed_load_c) begin
                            md5_data       <= mem[AW'(pos + PW'(feed_idx))];
                            md5_data_valid <= 1'b1;
                            md5_last       <= feed_idx == (str_bytes - LW'(1));
                            feed_idx       <= feed_idx + LW'(1);
                        end
                    end
                    S_WAIT_HASH: begin
                        if (hash_hit_c) begin
                            proc_match    <= 1'b1;
                            proc_byte_pos <= pos[15:0];
                        end else if (hash_miss_c) begin
                            pos <= pos + PW'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (drain_done_c) begin
                            proc_done <= 1'b1;
                            rd_ptr    <= AW'(proc_byte_pos);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/char_buff.md
# char_buff

Downstream processing stage for the command parser. It buffers the character stream delivered during a PROC command and slides a window of `str_len/8` bytes across it, one byte position at a time. Each window is streamed to an external MD5 core, and the returned digest is compared with the target hash. It reports done/match/position back to the parser and serves the matched string byte-by-byte for the RET command.

## Interface

Parameters:
- `BUFF_DEPTH`, 1024: buffer size in bytes; power of 2.
- `MAX_STR_BYTES`, 55: largest window length (one MD5 block).

Ports:
- `clk`  input  1  system clock
- `reset`  input  1  asynchronous, active-low reset
- `proc_start`  input  1  one-cycle pulse; begins a new PROC run
- `proc_num_bytes`  input  16  bytes to follow; sampled on `proc_start`
- `proc_data`  input  8  character byte
- `proc_data_valid`  input  1  `proc_data` qualifier, one byte per cycle high
- `proc_target_hash`  input  128  target digest, MSB first
- `proc_str_len`  input  16  window length in bits; sampled on `proc_start`
- `proc_match_char_next`  input  1  advance readout pointer
- `proc_done`  output  1  one-cycle pulse; run complete
- `proc_match`  output  1  window matched in last run
- `proc_byte_pos`  output  16  0-based start offset of matching window
- `proc_match_char`  output  8  buffer byte at readout pointer
- `md5_data`  output  8  window byte to MD5 core
- `md5_data_valid`  output  1  `md5_data` qualifier
- `md5_last`  output  1  marks final byte of window
- `md5_ready`  input  1  core accepts byte when valid&ready
- `md5_hash_valid`  input  1  one-cycle pulse, digest ready
- `md5_hash`  input  128  digest

## Operation

- `L = proc_str_len[15:3]` is latched at `proc_start`. `N = min(proc_num_bytes, BUFF_DEPTH)`.
- Write side runs independently of the FSM. Each `proc_data_valid` byte is written at `wr_ptr`, and `wr_ptr` is incremented.
  - Bytes with index ≥ `BUFF_DEPTH` are counted but not stored.
  - `rx_count` reaching `proc_num_bytes` means input is complete.
- `pos` is the current window start, cleared at `proc_start`.
- FSM states:
  - **IDLE:** on `proc_start`, latch parameters, clear `wr_ptr`, `rx_count`, `pos`, `proc_match`, `proc_byte_pos`, then go to FILL.
  - **FILL:**
    - If `L==0`, `L>MAX_STR_BYTES`, or `pos+L>N`, go to DRAIN.
    - Otherwise, when `wr_ptr ≥ pos+L`, go to FEED.
  - **FEED:** stream `buf[pos]..buf[pos+L-1]` with valid/ready. Assert `md5_last` with the final byte, then go to WAIT_HASH.
  - **WAIT_HASH:** on `md5_hash_valid`, compare `md5_hash` with `proc_target_hash`.
    - Equal: set `proc_match=1` and `proc_byte_pos=pos`, then go to DRAIN.
    - Not equal: `pos<=pos+1`, then go to FILL.
  - **DRAIN:** wait until `rx_count==proc_num_bytes`, then go to DONE.
  - **DONE:** pulse `proc_done`, load `rd_ptr<=proc_byte_pos`, then go to IDLE.
- A `proc_start` in any non-IDLE state aborts the run and restarts it as if from IDLE. An in-flight MD5 digest is ignored.
- Readout:
  - `proc_match_char` is registered: `buf[rd_ptr]`.
  - `proc_match_char_next` high for one cycle increments `rd_ptr` by 1, modulo `BUFF_DEPTH`.
  - Readout is valid only after `proc_done` and until the next `proc_start`.
- Arithmetic: `pos`, `wr_ptr`, and comparisons are 17-bit, so `pos+L` never wraps. `proc_byte_pos` holds `pos[15:0]`.

## Timing

- Reset: every output 0. FSM goes to IDLE, and all pointers and counters are 0. Buffer contents are don't-care.
- Reset mid-operation: outputs are 0 asynchronously. No `proc_done` is issued for the aborted run.
- `md5_data`/`md5_last` must stay stable while `md5_data_valid` is high and `md5_ready` is low. Valid never drops until the byte is accepted.
- FEED throughput is at least one byte per 2 cycles.
- Match decision happens in the cycle after `md5_hash_valid`.
- `proc_done` is high for exactly one cycle, at least 1 cycle after the last input byte. `proc_match`/`proc_byte_pos` are stable when it rises and held until the next `proc_start`.
- `proc_match_char` reflects the new `rd_ptr` within 2 cycles of `proc_match_char_next`. It reflects `buf[proc_byte_pos]` within 2 cycles of `proc_done`.
- `proc_data_valid` in the same cycle as `proc_start` is ignored.

## Test plan

- **Reset:** assert `reset` low mid-stream → every output 0 immediately. A following `str_len=0x98`, N=19 run completes normally.
- **Match not at offset 0:** N=20, `str_len=0x98`, MD5 model matches window at pos 1 → 2 MD5 transactions of 19 bytes, `md5_last` on each 19th byte.
  - `proc_match=1`, `proc_byte_pos=1`, one `proc_done` pulse.
  - 19 next-pulses read bytes 1..19 in order.
- **No match:** N=21, L=19, no digest matches → 3 windows hashed, `proc_match=0`, `proc_byte_pos=0`, one `proc_done`.
- **Short input:** N=5, L=19 → zero MD5 transactions. `proc_done` follows the 5th byte, `proc_match=0`.
- **Early match with drain:** match at pos 0, N=40 → no further MD5 transactions after the match. `proc_done` only after byte 40 is accepted.
- **Back-pressure and restart:** `md5_ready` toggles 0/1 each cycle → `md5_data` stable while unaccepted. A second `proc_start` mid-FEED restarts cleanly, and the stale digest is ignored.
